ir_led_arbiter: RTL

Round-robin arbiter that shares the single IR LED output between the four car-colour packet transmitters (yellow, green, blue, red). It sits between the transmitter state machines and the LED output multiplexer. It drives that multiplexer's one-hot COLOUR_SEL so that exactly one transmitter owns the LED for a whole packet, with a silent guard gap between owners. A hold timeout revokes a grant if its owner never signals completion.

---
 rtl/ir_pkg.sv | 34 +++
 rtl/rr_pick.sv | 30 +++
 rtl/ir_led_arbiter.sv | 127 ++++++++++++
 3 files changed

// File: rtl/ir_pkg.sv
// rtl/ir_pkg.sv - car indices, LED mux selects and arbiter state encoding for the IR LED arbiter
package ir_pkg;

  localparam logic [1:0] CAR_YELLOW = 2'd0;
  localparam logic [1:0] CAR_GREEN  = 2'd1;
  localparam logic [1:0] CAR_BLUE   = 2'd2;
  localparam logic [1:0] CAR_RED    = 2'd3;

  localparam logic [3:0] SEL_YELLOW = 4'b0001;
  localparam logic [3:0] SEL_GREEN  = 4'b0010;
  localparam logic [3:0] SEL_BLUE   = 4'b0100;
  localparam logic [3:0] SEL_RED    = 4'b1000;
  localparam logic [3:0] SEL_NONE   = 4'b0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } arb_state_t;

  // One-hot LED mux select for a car index.
  function automatic logic [3:0] car_sel(input logic [1:0] idx);
    logic [3:0] sel;
    case (idx)
      CAR_YELLOW: sel = SEL_YELLOW;
      CAR_GREEN:  sel = SEL_GREEN;
      CAR_BLUE:   sel = SEL_BLUE;
      CAR_RED:    sel = SEL_RED;
      default:    sel = SEL_NONE;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational round-robin pick over four eligible requesters
module rr_pick
  import ir_pkg::*;
(
  input  logic [3:0] i_eligible,
  input  logic [1:0] i_last,
  output logic [3:0] o_pick,
  output logic [1:0] o_idx
);

  logic       w_found;
  logic [1:0] w_cand;

  // Scan upward from the slot after the last owner, wrapping, and take the first eligible car.
  always_comb begin
    o_pick  = SEL_NONE;
    o_idx   = i_last;
    w_found = 1'b0;
    w_cand  = i_last;
    for (int k = 1; k <= 4; k++) begin
      w_cand = i_last + 2'(k);
      if (!w_found && i_eligible[w_cand]) begin
        w_found = 1'b1;
        o_pick  = car_sel(w_cand);
        o_idx   = w_cand;
      end
    end
  end

endmodule

// File: rtl/ir_led_arbiter.sv
// rtl/ir_led_arbiter.sv - round-robin owner of the shared IR LED with guard gap and hold timeout
module ir_led_arbiter
  import ir_pkg::*;
#(
  parameter int MAX_HOLD     = 2500000,
  parameter int GUARD_CYCLES = 50000
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_req,
  input  logic [3:0] i_done,
  input  logic [3:0] i_enable_mask,
  output logic [3:0] o_colour_sel,
  output logic       o_grant_valid,
  output logic       o_timeout
);

  localparam int HOLD_W  = $clog2(MAX_HOLD + 1);
  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(MAX_HOLD - 1);
  localparam logic [HOLD_W-1:0]  HOLD_SAT   = HOLD_W'(MAX_HOLD);
  localparam logic [GUARD_W-1:0] GUARD_LAST = GUARD_W'(GUARD_CYCLES - 1);
  localparam logic [GUARD_W-1:0] GUARD_SAT  = GUARD_W'(GUARD_CYCLES);

  arb_state_t         r_state;
  arb_state_t         w_state_nxt;
  logic [3:0]         r_colour_sel;
  logic [3:0]         w_colour_sel_nxt;
  logic [1:0]         r_last;
  logic [1:0]         w_last_nxt;
  logic [HOLD_W-1:0]  r_hold_cnt;
  logic [HOLD_W-1:0]  w_hold_cnt_nxt;
  logic [GUARD_W-1:0] r_guard_cnt;
  logic [GUARD_W-1:0] w_guard_cnt_nxt;
  logic               r_timeout;
  logic               w_timeout_nxt;

  logic [3:0]         w_eligible;
  logic [3:0]         w_pick;
  logic [1:0]         w_pick_idx;
  logic               w_owner_end;

  // The mask only gates new arbitration; the running owner is judged on its own REQ/DONE.
  assign w_eligible  = i_req & i_enable_mask;
  assign w_owner_end = i_done[r_last] | ~i_req[r_last];

  rr_pick u_rr_pick (
    .i_eligible (w_eligible),
    .i_last     (r_last),
    .o_pick     (w_pick),
    .o_idx      (w_pick_idx)
  );

  // Next-state and next-output decode for the IDLE / GRANT / GUARD cycle.
  always_comb begin
    w_state_nxt      = r_state;
    w_colour_sel_nxt = r_colour_sel;
    w_last_nxt       = r_last;
    w_hold_cnt_nxt   = r_hold_cnt;
    w_guard_cnt_nxt  = r_guard_cnt;
    w_timeout_nxt    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        w_colour_sel_nxt = SEL_NONE;
        if (|w_eligible) begin
          w_state_nxt      = ST_GRANT;
          w_colour_sel_nxt = w_pick;
          w_last_nxt       = w_pick_idx;
          w_hold_cnt_nxt   = '0;
        end
      end
      ST_GRANT: begin
        if (r_hold_cnt != HOLD_SAT) begin
          w_hold_cnt_nxt = r_hold_cnt + HOLD_W'(1);
        end
        // A normal end wins over a coincident timeout, so no TIMEOUT pulse then.
        if (w_owner_end) begin
          w_state_nxt      = ST_GUARD;
          w_colour_sel_nxt = SEL_NONE;
          w_guard_cnt_nxt  = '0;
        end else if (r_hold_cnt >= HOLD_LAST) begin
          w_state_nxt      = ST_GUARD;
          w_colour_sel_nxt = SEL_NONE;
          w_guard_cnt_nxt  = '0;
          w_timeout_nxt    = 1'b1;
        end
      end
      ST_GUARD: begin
        w_colour_sel_nxt = SEL_NONE;
        if (r_guard_cnt >= GUARD_LAST) begin
          w_state_nxt = ST_IDLE;
        end else if (r_guard_cnt != GUARD_SAT) begin
          w_guard_cnt_nxt = r_guard_cnt + GUARD_W'(1);
        end
      end
      default: begin
        w_state_nxt      = ST_IDLE;
        w_colour_sel_nxt = SEL_NONE;
      end
    endcase
  end

  // State and output registers; reset blanks the LED immediately.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_colour_sel <= SEL_NONE;
      r_last       <= CAR_RED;
      r_hold_cnt   <= '0;
      r_guard_cnt  <= '0;
      r_timeout    <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_colour_sel <= w_colour_sel_nxt;
      r_last       <= w_last_nxt;
      r_hold_cnt   <= w_hold_cnt_nxt;
      r_guard_cnt  <= w_guard_cnt_nxt;
      r_timeout    <= w_timeout_nxt;
    end
  end

  assign o_colour_sel  = r_colour_sel;
  assign o_grant_valid = |r_colour_sel;
  assign o_timeout     = r_timeout;

endmodule
